// File: rtl/snail_mc_if.sv
// Shared program/data memory port of the SNAIL multi-cycle core.
// The master holds req/we/addr/wdat stable until the cycle in which rdy is high.
interface snail_mc_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdat;
  logic [DW-1:0] rdat;
  logic          rdy;

  modport master (output req, we, addr, wdat, input rdat, rdy);
  modport slave  (input req, we, addr, wdat, output rdat, rdy);
endinterface

// File: rtl/snail_mc.sv
// snail_mc: multi-cycle SNAIL core executing over one req/rdy memory port.
// Define SNAIL_MC_TMO_EN to add the handshake timeout and the mem_err output.
//
// state | meaning
// F0    | fetch w0 at PC (HLT halts, NOP/unknown advance PC by 1)
// F1    | fetch w1 at PC+1 (register fields or JMP target)
// F2    | fetch w2 at PC+2 (rC or immediate)
// EX    | execute, no memory access
// MEM   | LD/ST data access at rA+imm
// HALT  | stopped, no requests until reset
module snail_mc #(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int TMO = 16
) (
  input  logic       clk,
  input  logic       rst_,
  snail_mc_if.master mem,
  output logic       halted
`ifdef SNAIL_MC_TMO_EN
  ,
  output logic       mem_err
`endif
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_OPR = 4'h1;
  localparam logic [3:0] OP_OPI = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JXX = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_OR  = 4'h3;
  localparam logic [3:0] F_XOR = 4'h4;
  localparam logic [3:0] F_SHL = 4'h5;
  localparam logic [3:0] F_SHR = 4'h6;
  localparam logic [3:0] F_MOV = 4'h7;

  localparam logic [3:0] C_BEQ = 4'h0;
  localparam logic [3:0] C_BNE = 4'h1;
  localparam logic [3:0] C_BLT = 4'h2;
  localparam logic [3:0] C_BGT = 4'h3;

  typedef enum logic [2:0] {
    S_F0, S_F1, S_F2, S_EX, S_MEM, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic          halted_q, halted_d;
  logic          z_q, z_d, g_q, g_d;
  logic [7:0]    w0_q, w0_d;
  logic [2:0]    ra_q, ra_d, rb_q, rb_d;
  logic [AW-1:0] jt_q, jt_d;
  logic [DW-1:0] w2_q, w2_d;
  logic [DW-1:0] rf_q [8];

  logic          rf_we;
  logic [2:0]    rf_wa;
  logic [DW-1:0] rf_wd;

  logic [3:0]    ins, fun;
  logic [DW-1:0] ra_val, rb_val, alu_b, alu_res;
  logic [AW-1:0] pc_p1, pc_p2, pc_p3;
  logic          done, taken;

  function automatic logic [DW-1:0] alu(input logic [3:0] f,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (f)
      F_ADD:   r = a + b;
      F_SUB:   r = a - b;
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_XOR:   r = a ^ b;
      F_SHL:   r = a << 1;
      F_SHR:   r = a >> 1;
      F_MOV:   r = b;
      default: r = b;
    endcase
    return r;
  endfunction

  assign ins     = w0_q[7:4];
  assign fun     = w0_q[3:0];
  assign ra_val  = rf_q[ra_q];
  assign rb_val  = rf_q[rb_q];
  assign alu_b   = (ins == OP_OPR) ? rb_val : w2_q;
  assign alu_res = alu(fun, ra_val, alu_b);
  assign pc_p1   = pc_q + AW'(1);
  assign pc_p2   = pc_q + AW'(2);
  assign pc_p3   = pc_q + AW'(3);
  assign done    = req_q & mem.rdy;

  always_comb begin
    case (fun)
      C_BEQ:   taken = z_q;
      C_BNE:   taken = ~z_q;
      C_BLT:   taken = ~z_q & ~g_q;
      C_BGT:   taken = g_q;
      default: taken = 1'b0;
    endcase
  end

`ifdef SNAIL_MC_TMO_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO != 0);
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    halted_d = halted_q;
    z_d      = z_q;
    g_d      = g_q;
    w0_d     = w0_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    jt_d     = jt_q;
    w2_d     = w2_q;
    rf_we    = 1'b0;
    rf_wa    = 3'd0;
    rf_wd    = '0;

    case (state_q)
      S_F0: begin
        // only the first fetch after reset starts from an idle port
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (done) begin
          case (mem.rdat[7:4])
            OP_HLT: begin
              req_d    = 1'b0;
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            OP_OPR, OP_OPI, OP_JMP, OP_JXX, OP_LD, OP_ST: begin
              w0_d    = mem.rdat[7:0];
              addr_d  = pc_p1;
              state_d = S_F1;
            end
            default: begin
              pc_d   = pc_p1;
              addr_d = pc_p1;
            end
          endcase
        end
      end
      S_F1: begin
        if (done) begin
          ra_d = mem.rdat[6:4];
          rb_d = mem.rdat[2:0];
          jt_d = AW'(mem.rdat);
          if (ins == OP_JMP) begin
            req_d   = 1'b0;
            state_d = S_EX;
          end else begin
            addr_d  = pc_p2;
            state_d = S_F2;
          end
        end
      end
      S_F2: begin
        if (done) begin
          w2_d    = mem.rdat;
          req_d   = 1'b0;
          state_d = S_EX;
        end
      end
      S_EX: begin
        req_d   = 1'b1;
        we_d    = 1'b0;
        pc_d    = pc_p3;
        addr_d  = pc_p3;
        state_d = S_F0;
        case (ins)
          OP_OPR, OP_OPI: begin
            rf_we = 1'b1;
            rf_wa = (ins == OP_OPR) ? w2_q[6:4] : rb_q;
            rf_wd = alu_res;
            z_d   = (alu_res == '0);
            g_d   = (alu_res != '0) & ~alu_res[DW-1];
          end
          OP_JMP: begin
            pc_d   = jt_q;
            addr_d = jt_q;
          end
          OP_JXX: begin
            if (taken) begin
              pc_d   = AW'(w2_q);
              addr_d = AW'(w2_q);
            end
          end
          OP_LD, OP_ST: begin
            pc_d    = pc_q;
            addr_d  = AW'(ra_val + w2_q);
            we_d    = (ins == OP_ST);
            state_d = S_MEM;
            if (ins == OP_ST) wdat_d = rb_val;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (done) begin
          if (!we_q) begin
            rf_we = 1'b1;
            rf_wa = rb_q;
            rf_wd = mem.rdat;
          end
          we_d    = 1'b0;
          pc_d    = pc_p3;
          addr_d  = pc_p3;
          state_d = S_F0;
        end
      end
      S_HALT: ;
      default: state_d = S_F0;
    endcase

`ifdef SNAIL_MC_TMO_EN
    tmo_d = tmo_q;
    err_d = err_q;
    if (done) tmo_d = '0;
    else if (req_q) tmo_d = tmo_q + TW'(1);
    if (req_q && !mem.rdy && (tmo_q == TW'(TMO))) begin
      req_d    = 1'b0;
      halted_d = 1'b1;
      err_d    = 1'b1;
      tmo_d    = '0;
      state_d  = S_HALT;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q  <= S_F0;
      pc_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      halted_q <= 1'b0;
      z_q      <= 1'b0;
      g_q      <= 1'b0;
      w0_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      jt_q     <= '0;
      w2_q     <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      halted_q <= halted_d;
      z_q      <= z_d;
      g_q      <= g_d;
      w0_q     <= w0_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      jt_q     <= jt_d;
      w2_q     <= w2_d;
      // r0 is never written, so it keeps its reset value of zero
      if (rf_we && (rf_wa != 3'd0)) rf_q[rf_wa] <= rf_wd;
    end
  end

`ifdef SNAIL_MC_TMO_EN
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign mem_err = err_q;
`endif

  assign mem.req  = req_q;
  assign mem.we   = we_q;
  assign mem.addr = addr_q;
  assign mem.wdat = wdat_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_snail_mc.sv
// Directed bench for snail_mc: DW=8 core with a wait-state memory model,
// plus a DW=16 core running a small wrap/flag program.
module tb_snail_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  snail_mc_if #(.DW(8),  .AW(8)) m8  ();
  snail_mc_if #(.DW(16), .AW(8)) m16 ();
  logic halted8, halted16;
`ifdef SNAIL_MC_TMO_EN
  logic err8, err16;
`endif

  snail_mc #(.DW(8), .AW(8), .TMO(16)) dut8 (
    .clk(clk), .rst_(rst), .mem(m8), .halted(halted8)
`ifdef SNAIL_MC_TMO_EN
    , .mem_err(err8)
`endif
  );

  snail_mc #(.DW(16), .AW(8), .TMO(16)) dut16 (
    .clk(clk), .rst_(rst), .mem(m16), .halted(halted16)
`ifdef SNAIL_MC_TMO_EN
    , .mem_err(err16)
`endif
  );

  // DW=8 memory model: configurable wait states, write stalls, logs
  logic [7:0] mem8 [256];
  logic [7:0] wmem [256];
  bit         wv   [256];
  int         waits = 0;
  bit         stall_all = 0;
  bit         stall_wr = 0;
  int         wcnt = 0;
  bit         open = 0;
  logic [7:0] a_addr, a_wdat;
  logic       a_we;
  int         stab_bad = 0;
  int         wr_cnt = 0;
  logic [7:0] wr_addr = '0, wr_dat = '0;
  logic [7:0] rlog [64];
  int         rcnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      m8.rdy = 1'b0; m8.rdat = '0; open = 0; rcnt = 0; wr_cnt = 0;
      for (int i = 0; i < 256; i++) wv[i] = 0;
    end else if (m8.req) begin
      if (!open) begin
        open = 1; wcnt = 0;
        a_addr = m8.addr; a_we = m8.we; a_wdat = m8.wdat;
      end else if (m8.addr !== a_addr || m8.we !== a_we || m8.wdat !== a_wdat) begin
        stab_bad++;
      end
      if (stall_all || (stall_wr && m8.we) || wcnt < waits) begin
        m8.rdy = 1'b0; wcnt++;
      end else begin
        m8.rdy = 1'b1; open = 0;
        if (m8.we) begin
          wmem[m8.addr] = m8.wdat; wv[m8.addr] = 1;
          wr_cnt++; wr_addr = m8.addr; wr_dat = m8.wdat;
        end else begin
          m8.rdat = wv[m8.addr] ? wmem[m8.addr] : mem8[m8.addr];
          if (rcnt < 64) rlog[rcnt] = m8.addr;
          rcnt++;
        end
      end
    end else begin
      m8.rdy = 1'b0; open = 0;
    end
  end

  // DW=16 memory model: always ready
  logic [15:0] mem16 [256];
  int          w16_cnt = 0;
  logic [7:0]  w16_addr = '0;
  logic [15:0] w16_dat = '0;

  always @(negedge clk) begin
    if (rst) begin
      m16.rdy = 1'b0; m16.rdat = '0; w16_cnt = 0;
    end else begin
      m16.rdy = m16.req;
      if (m16.req) begin
        if (m16.we) begin
          w16_cnt++; w16_addr = m16.addr; w16_dat = m16.wdat;
        end else begin
          m16.rdat = mem16[m16.addr];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int t);
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m8.req) begin t = cyc; break; end
    end
    chk("req_seen", (t >= 0), 1);
  endtask

  task automatic wait_halt(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted8) begin t = cyc; break; end
    end
    chk("halt_seen", (t >= 0), 1);
  endtask

  task automatic clr8();
    for (int i = 0; i < 256; i++) mem8[i] = 8'h70;
  endtask

  task automatic put3(input int a, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    mem8[a] = b0; mem8[a+1] = b1; mem8[a+2] = b2;
  endtask

  task automatic load_prog1();
    clr8();
    put3(0, 8'h20, 8'h01, 8'h05);  // OPI ADD r1 = r0 + 5
    put3(3, 8'h10, 8'h11, 8'h20);  // OPR ADD r2 = r1 + r1
    put3(6, 8'h60, 8'h02, 8'h40);  // ST r2 -> [r0+0x40]
    put3(9, 8'h50, 8'h03, 8'h40);  // LD r3 <- [r0+0x40]
    mem8[12] = 8'h70;              // HLT
  endtask

  initial begin
    int t0, t1;
    rst = 1'b1;
    load_prog1();
    for (int i = 0; i < 256; i++) mem16[i] = 16'h0070;
    mem16[0]  = 16'h0020; mem16[1]  = 16'h0001; mem16[2]  = 16'hFFFF;
    mem16[3]  = 16'h0020; mem16[4]  = 16'h0012; mem16[5]  = 16'h0001;
    mem16[6]  = 16'h0040; mem16[7]  = 16'h0000; mem16[8]  = 16'h0010;
    mem16[16] = 16'h0060; mem16[17] = 16'h0001; mem16[18] = 16'h0080;
    repeat (2) @(negedge clk);
    chk("rst_req",    m8.req,   0);
    chk("rst_addr",   m8.addr,  0);
    chk("rst_halted", halted8,  0);
    rst = 1'b0;

    // zero-wait program
    wait_req(t0);
    chk("p1_first_addr", m8.addr, 0);
    chk("p1_first_we",   m8.we,   0);
    wait_halt(100, t1);
    chk("p1_cycles", t1 - t0, 19);
    chk("p1_wr_cnt", wr_cnt,  1);
    chk("p1_wr_addr", wr_addr, 8'h40);
    chk("p1_wr_dat", wr_dat,  8'h0A);
    chk("p1_r3", dut8.rf_q[3], 8'h0A);
    chk("p1_halt_noreq", m8.req, 0);
    repeat (2) @(negedge clk);
    chk("w16_halted", halted16, 1);
    chk("w16_wr_addr", w16_addr, 8'h80);
    chk("w16_wr_dat", w16_dat, 16'hFFFF);
    chk("w16_r2_zero", dut16.rf_q[2], 16'h0000);
    chk("w16_z_flag", dut16.z_q, 1);

    // same program with three wait states per access
    @(negedge clk); rst = 1'b1; waits = 3;
    @(negedge clk); rst = 1'b0;
    wait_req(t0);
    wait_halt(200, t1);
    chk("ws_cycles", t1 - t0, 64);
    chk("ws_wr_addr", wr_addr, 8'h40);
    chk("ws_wr_dat", wr_dat, 8'h0A);
    chk("ws_r3", dut8.rf_q[3], 8'h0A);
    chk("ws_stable", stab_bad, 0);

    // reset while the store is stalled in MEM
    @(negedge clk); rst = 1'b1; waits = 0; stall_wr = 1;
    @(negedge clk); rst = 1'b0;
    t0 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m8.req && m8.we) begin t0 = cyc; break; end
    end
    chk("mem_st_seen", (t0 >= 0), 1);
    chk("mem_st_wdat", m8.wdat, 8'h0A);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_req",    m8.req,  0);
    chk("arst_we",     m8.we,   0);
    chk("arst_addr",   m8.addr, 0);
    chk("arst_wdat",   m8.wdat, 0);
    chk("arst_halted", halted8, 0);
    chk("arst_nowrite", wr_cnt, 0);
    @(negedge clk); stall_wr = 0; rst = 1'b0;
    wait_req(t0);
    chk("restart_addr", m8.addr, 0);
    chk("restart_we",   m8.we,   0);
    wait_halt(100, t1);
    chk("restart_cycles", t1 - t0, 19);

    // branches
    @(negedge clk); rst = 1'b1;
    clr8();
    put3(0,     8'h20, 8'h01, 8'h07);  // r1 = 7
    put3(3,     8'h20, 8'h02, 8'h07);  // r2 = 7
    put3(6,     8'h11, 8'h12, 8'h30);  // r3 = r1 - r2 -> Z
    put3(9,     8'h40, 8'h00, 8'h20);  // BEQ 0x20
    put3(8'h20, 8'h41, 8'h00, 8'h50);  // BNE 0x50 (not taken)
    put3(8'h23, 8'h20, 8'h01, 8'h09);  // r1 = 9
    put3(8'h26, 8'h11, 8'h12, 8'h30);  // r3 = r1 - r2 -> G
    put3(8'h29, 8'h43, 8'h00, 8'h60);  // BGT 0x60
    @(negedge clk); rst = 1'b0;
    wait_halt(200, t1);
    chk("br_beq_target", rlog[12], 8'h20);
    chk("br_bne_fall",   rlog[15], 8'h23);
    chk("br_bgt_target", rlog[24], 8'h60);
    chk("br_reads",      rcnt,     25);
    chk("br_r3",         dut8.rf_q[3], 8'h02);

    // PC wrap: JMP 0xFF, NOP at 0xFF, next fetch at 0x00
    @(negedge clk); rst = 1'b1;
    clr8();
    mem8[0] = 8'h30; mem8[1] = 8'hFF; mem8[255] = 8'h00;
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("wrap_jmp_tgt", rlog[2], 8'hFF);
    chk("wrap_next",    rlog[3], 8'h00);
    chk("wrap_next2",   rlog[4], 8'h01);

`ifdef SNAIL_MC_TMO_EN
    @(negedge clk); rst = 1'b1; stall_all = 1;
    @(negedge clk); rst = 1'b0;
    wait_req(t0);
    t1 = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err8) begin t1 = cyc; break; end
    end
    chk("tmo_cycles", t1 - t0, 17);
    chk("tmo_halted", halted8, 1);
    chk("tmo_req",    m8.req,  0);
    stall_all = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
